multi_slice_detector: RTL and testbench
=======================================

Name: multi_slice_detector

Overview:
- Parametrised, sequential hit-test engine.
- Checks one blade/cursor sample against NUM_OBJ square fruit hit-boxes (half-size HALF, centred on each object position).
- Accumulates sticky per-object hit flags and reports per-sample results for the game-logic/score block.
- Sits between the cursor tracker and the fruit controller; scans one object per clock to keep a single comparator set.

Parameters:
- NUM_OBJ, 4, number of objects scanned per sample (1..32)
- W, 10, coordinate width in bits
- HALF, 16, hit-box half-size in pixels (< 2^(W-1))

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- cur_x  input  W  cursor x coordinate
- cur_y  input  W  cursor y coordinate
- sample  input  1  single-cycle strobe: new cursor sample to test
- obj_x  input  NUM_OBJ*W  object centre x; object i at bits [i*W +: W]
- obj_y  input  NUM_OBJ*W  object centre y, same packing
- obj_en  input  NUM_OBJ  object i active; inactive objects never hit
- clear  input  1  single-cycle: clear sticky hit_mask and overrun
- busy  output  1  scan in progress (state != IDLE)
- done  output  1  one-cycle pulse: scan complete, scan outputs valid
- new_mask  output  NUM_OBJ  objects hit this sample that were not already in hit_mask
- hit_any  output  1  |new_mask, valid with done
- hit_count  output  $clog2(NUM_OBJ+1)  popcount(new_mask), valid with done
- hit_mask  output  NUM_OBJ  sticky accumulated hit flags
- overrun  output  1  sticky: sample arrived while busy

Behaviour:
- Reset (async, rst=1): state IDLE, idx=0, latched cursor=0, scan_mask=0; all outputs 0.
- FSM states:
  - IDLE: on sample=1, latch cur_x/cur_y, clear scan_mask, idx<=0, go SCAN.
  - SCAN: each cycle evaluate object idx and set scan_mask[idx] on hit. idx<=idx+1; after idx==NUM_OBJ-1 go DONE.
  - DONE: one cycle, update results, return IDLE.
- Hit rule for object i, with comparisons done in W+1 bits:
  - lo_x = (x0 < HALF) ? 0 : x0-HALF; hi_x = x0+HALF with no wrap, so hi can exceed 2^W-1.
  - Same for y.
  - hit = obj_en[i] & (lo_x < cx < hi_x) & (lo_y < cy < hi_y). Both bounds strict.
- obj_x/obj_y/obj_en for index i are sampled in the SCAN cycle evaluating i. Cursor is the latched value.
- Timing: sample at edge E0 → busy high from E0; done high for exactly one cycle after edge E(NUM_OBJ+1). Sample-to-done latency is NUM_OBJ+1 clocks. Back-to-back samples are accepted from the cycle done is high; the IDLE check runs in that cycle.
- DONE-cycle register updates:
  - new_mask <= scan_mask & ~base, where base = clear ? 0 : hit_mask.
  - hit_mask <= base | scan_mask.
  - hit_any and hit_count derived from the same new_mask.
  - new_mask, hit_any and hit_count hold until the next DONE.
- clear outside DONE: hit_mask<=0, overrun<=0 next edge. Does not abort a running scan.
- sample while busy (SCAN/DONE): ignored, overrun<=1. A simultaneous clear wins: overrun stays 0.
- NUM_OBJ=1: SCAN lasts one cycle; latency 2.
- rst mid-scan: immediate abort, no done pulse, all state cleared.

Test Plan:
- W=10, HALF=16, NUM_OBJ=4; obj0=(100,100) en, others disabled; sample cur=(110,90) → done 5 cycles after sample; new_mask=0001, hit_any=1, hit_count=1, hit_mask=0001.
- Strict bounds: obj0=(100,100); cur=(116,100) → miss; cur=(84,100) → miss; cur=(115,115) → hit.
- Clamp/no-wrap: obj1=(5,500), cur=(0,500) → miss (0 > 0 false); cur=(1,500) → hit. obj2=(1015,500), cur=(1023,500) → hit (hi_x=1031).
- Sticky/clear: repeat the same hitting sample → new_mask=0000, hit_count=0, hit_mask unchanged. Assert clear in a later DONE cycle with the same hit → new_mask=0001, hit_mask=0001.
- Overrun: second sample 2 cycles after the first → ignored, overrun=1, single done. Then clear → overrun=0, hit_mask=0.
- Disabled/multi and reset: all four objects at (200,200), obj_en=1011 → new_mask=1011, hit_count=3. Assert rst in the 2nd SCAN cycle → busy=0 immediately, no done, all outputs 0.

Source files
------------

// File: rtl/multi_slice_detector.sv
// Sequential hit-test engine: checks one latched cursor sample against NUM_OBJ
// square hit-boxes, one object per clock, and accumulates sticky per-object hits.
module multi_slice_detector #(
    parameter int NUM_OBJ = 4,
    parameter int W       = 10,
    parameter int HALF    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [W-1:0]                 cur_x,
    input  logic [W-1:0]                 cur_y,
    input  logic                         sample,
    input  logic [NUM_OBJ*W-1:0]         obj_x,
    input  logic [NUM_OBJ*W-1:0]         obj_y,
    input  logic [NUM_OBJ-1:0]           obj_en,
    input  logic                         clear,
    output logic                         busy,
    output logic                         done,
    output logic [NUM_OBJ-1:0]           new_mask,
    output logic                         hit_any,
    output logic [$clog2(NUM_OBJ+1)-1:0] hit_count,
    output logic [NUM_OBJ-1:0]           hit_mask,
    output logic                         overrun
);
    localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int CNT_W = $clog2(NUM_OBJ + 1);
    localparam logic [W:0] HALF_E = (W+1)'(HALF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       cx_q, cx_d, cy_q, cy_d;
    logic [NUM_OBJ-1:0] scan_mask_q, scan_mask_d;
    logic [NUM_OBJ-1:0] new_mask_q, new_mask_d;
    logic [NUM_OBJ-1:0] hit_mask_q, hit_mask_d;
    logic               hit_any_q, hit_any_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;
    logic               overrun_q, overrun_d;
    logic               done_q, done_d;

    logic [W-1:0] obj_x_arr [NUM_OBJ];
    logic [W-1:0] obj_y_arr [NUM_OBJ];

    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_unpack
            assign obj_x_arr[gi] = obj_x[gi*W +: W];
            assign obj_y_arr[gi] = obj_y[gi*W +: W];
        end
    endgenerate

    // Single comparator set, muxed onto the object under scan. The extra bit
    // lets hi run past 2^W-1 instead of wrapping.
    logic [W:0] x0_e, y0_e, lo_x, hi_x, lo_y, hi_y, cx_e, cy_e;
    logic       obj_hit;

    always_comb begin
        x0_e    = {1'b0, obj_x_arr[idx_q]};
        y0_e    = {1'b0, obj_y_arr[idx_q]};
        cx_e    = {1'b0, cx_q};
        cy_e    = {1'b0, cy_q};
        lo_x    = (x0_e < HALF_E) ? '0 : x0_e - HALF_E;
        hi_x    = x0_e + HALF_E;
        lo_y    = (y0_e < HALF_E) ? '0 : y0_e - HALF_E;
        hi_y    = y0_e + HALF_E;
        obj_hit = obj_en[idx_q] && (lo_x < cx_e) && (cx_e < hi_x)
                                && (lo_y < cy_e) && (cy_e < hi_y);
    end

    logic [NUM_OBJ-1:0] base;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        scan_mask_d = scan_mask_q;
        new_mask_d  = new_mask_q;
        hit_mask_d  = hit_mask_q;
        hit_any_d   = hit_any_q;
        hit_count_d = hit_count_q;
        done_d      = 1'b0;
        base        = clear ? '0 : hit_mask_q;

        case (state_q)
            IDLE: begin
                if (sample) begin
                    cx_d        = cur_x;
                    cy_d        = cur_y;
                    scan_mask_d = '0;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (obj_hit) scan_mask_d[idx_q] = 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                new_mask_d = scan_mask_q & ~base;
                hit_mask_d = base | scan_mask_q;
                hit_any_d  = |new_mask_d;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (clear && state_q != DONE) hit_mask_d = '0;

        if (state_q == DONE) begin
            hit_count_d = '0;
            for (int i = 0; i < NUM_OBJ; i++)
                hit_count_d = hit_count_d + CNT_W'(new_mask_d[i]);
        end

        // clear beats a simultaneous overrunning sample
        if (clear)
            overrun_d = 1'b0;
        else if (sample && state_q != IDLE)
            overrun_d = 1'b1;
        else
            overrun_d = overrun_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            scan_mask_q <= '0;
            new_mask_q  <= '0;
            hit_mask_q  <= '0;
            hit_any_q   <= 1'b0;
            hit_count_q <= '0;
            overrun_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            scan_mask_q <= scan_mask_d;
            new_mask_q  <= new_mask_d;
            hit_mask_q  <= hit_mask_d;
            hit_any_q   <= hit_any_d;
            hit_count_q <= hit_count_d;
            overrun_q   <= overrun_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign new_mask  = new_mask_q;
    assign hit_any   = hit_any_q;
    assign hit_count = hit_count_q;
    assign hit_mask  = hit_mask_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_multi_slice_detector.sv
// Scoreboard bench for multi_slice_detector: directed samples push expected
// results, a negedge monitor pops and compares whenever done is high.
module tb_multi_slice_detector;
    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   cur_x = '0, cur_y = '0;
    logic           sample = 1'b0;
    logic [N*W-1:0] obj_x = '0, obj_y = '0;
    logic [N-1:0]   obj_en = '0;
    logic           clear = 1'b0;
    logic           busy, done, hit_any, overrun;
    logic [N-1:0]   new_mask, hit_mask;
    logic [2:0]     hit_count;

    multi_slice_detector #(.NUM_OBJ(N), .W(W), .HALF(16)) dut (
        .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .sample(sample),
        .obj_x(obj_x), .obj_y(obj_y), .obj_en(obj_en), .clear(clear),
        .busy(busy), .done(done), .new_mask(new_mask), .hit_any(hit_any),
        .hit_count(hit_count), .hit_mask(hit_mask), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] nm;
        logic         any;
        logic [2:0]   cnt;
        logic [N-1:0] hm;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_latency", cyc, e.cyc);
                chk("new_mask", new_mask, e.nm);
                chk("hit_any", hit_any, e.any);
                chk("hit_count", hit_count, e.cnt);
                chk("hit_mask", hit_mask, e.hm);
                chk("overrun", overrun, e.ov);
                $display("done: new_mask=%b hit_any=%b hit_count=%0d hit_mask=%b overrun=%b",
                         new_mask, hit_any, hit_count, hit_mask, overrun);
            end
        end
    end

    function automatic logic [2:0] popc(input logic [N-1:0] m);
        logic [2:0] c = '0;
        for (int i = 0; i < N; i++) c = c + 3'(m[i]);
        return c;
    endfunction

    task automatic set_obj(input int i, input int x, input int y);
        obj_x[i*W +: W] = W'(x);
        obj_y[i*W +: W] = W'(y);
    endtask

    // Issue one sample; optionally re-strobe sample before edge ovr_at and/or
    // assert clear during the DONE cycle. Returns #1 after the done edge.
    task automatic run_sample(input int cx, input int cy, input logic [N-1:0] nm,
                              input logic [N-1:0] hm, input logic ov,
                              input int ovr_at, input bit clr_done);
        exp_t e;
        cur_x  = W'(cx);
        cur_y  = W'(cy);
        sample = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0;
        e.nm = nm; e.any = |nm; e.cnt = popc(nm); e.hm = hm; e.ov = ov; e.cyc = cyc + N + 1;
        exp_q.push_back(e);
        chk("busy_in_scan", busy, 1'b1);
        $display("sample: cur=(%0d,%0d) obj_en=%b", cx, cy, obj_en);
        for (int k = 1; k <= N; k++) begin
            if (k == ovr_at) sample = 1'b1;
            @(posedge clk); #1;
            sample = 1'b0;
            if (k == N && clr_done) clear = 1'b1;
        end
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_hit_mask", hit_mask, '0);
        chk("clear_overrun", overrun, 1'b0);
        $display("clear: hit_mask=%b overrun=%b", hit_mask, overrun);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_outputs", {new_mask, hit_any, hit_count, hit_mask, overrun}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic hit
        set_obj(0, 100, 100);
        obj_en = 4'b0001;
        run_sample(110, 90, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
        pulse_clear();

        // strict bounds
        run_sample(116, 100, 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        run_sample(84, 100, 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        run_sample(115, 115, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
        pulse_clear();

        // clamp at zero and no wrap at the top
        set_obj(1, 5, 500);
        obj_en = 4'b0010;
        run_sample(0, 500, 4'b0000, 4'b0000, 1'b0, 0, 1'b0);
        run_sample(1, 500, 4'b0010, 4'b0010, 1'b0, 0, 1'b0);
        set_obj(2, 1015, 500);
        obj_en = 4'b0110;
        run_sample(1023, 500, 4'b0100, 4'b0110, 1'b0, 0, 1'b0);
        pulse_clear();

        // sticky mask and clear during DONE
        obj_en = 4'b0001;
        run_sample(110, 90, 4'b0001, 4'b0001, 1'b0, 0, 1'b0);
        run_sample(110, 90, 4'b0000, 4'b0001, 1'b0, 0, 1'b0);
        run_sample(110, 90, 4'b0001, 4'b0001, 1'b0, 0, 1'b1);

        // overrun: second sample two cycles in is dropped
        run_sample(110, 90, 4'b0000, 4'b0001, 1'b1, 2, 1'b0);
        repeat (N + 2) @(posedge clk);
        #1;
        chk("overrun_single_done", exp_q.size(), 0);
        pulse_clear();

        // disabled object among overlapping objects
        for (int i = 0; i < N; i++) set_obj(i, 200, 200);
        obj_en = 4'b1011;
        run_sample(200, 200, 4'b1011, 4'b1011, 1'b0, 0, 1'b0);

        // reset in second SCAN cycle
        cur_x = 10'd200; cur_y = 10'd200;
        sample = 1'b1;
        @(posedge clk); #1;
        sample = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_outputs", {new_mask, hit_any, hit_count, hit_mask, overrun}, '0);
        $display("reset mid-scan: busy=%b hit_mask=%b", busy, hit_mask);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (N + 4) @(posedge clk);
        #1;
        chk("midrst_no_done_pending", exp_q.size(), 0);
        chk("midrst_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
